cc_ctrl: RTL and testbench

CC_CTRL -- requirements
Module: cc_ctrl

---
 rtl/cc_pkg.sv | 17 +
 rtl/cc_if.sv | 25 ++
 rtl/cc_block.sv | 131 +++++++++++++
 rtl/cc_ctrl.sv | 119 +++++++++++
 tb/tb_cc_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_pkg.sv
// Shared types and constants for the ChaCha20 keystream controller and its block core.
package cc_pkg;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_CAPT, S_FIN} state_e;
  typedef enum logic [2:0] {C_IDLE, C_LOAD, C_RUN, C_ADD, C_DONE} core_state_e;

  // Cycles from the core request to the core done pulse.
  localparam int unsigned CORE_LAT = 243;

  // "expand 32-byte k", word 0 in the low bits.
  localparam logic [127:0] CHACHA_C = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

endpackage

// File: rtl/cc_if.sv
// Job request and keystream output bundle of cc_ctrl; slave is the controller side.
interface cc_if;
  logic [255:0] i_key;
  logic [95:0]  i_non;
  logic [31:0]  i_cnt;
  logic [15:0]  i_nblk;
  logic         i_start;
  logic [511:0] o_ks;
  logic         o_ks_valid;
  logic         i_ks_ready;
  logic         o_ks_last;
  logic         o_busy;
  logic         o_done;
  logic         o_err;

  modport slave (
    input  i_key, i_non, i_cnt, i_nblk, i_start, i_ks_ready,
    output o_ks, o_ks_valid, o_ks_last, o_busy, o_done, o_err
  );

  modport master (
    output i_key, i_non, i_cnt, i_nblk, i_start, i_ks_ready,
    input  o_ks, o_ks_valid, o_ks_last, o_busy, o_done, o_err
  );
endinterface

// File: rtl/cc_block.sv
// ChaCha20 block core, one third of a quarter-round per cycle; word i of key/nonce/block
// sits at bits [32*i +: 32] (little-endian words as in RFC 8439).
module cc_block
  import cc_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_b,
  input  logic         i_qr,
  input  logic [255:0] i_key,
  input  logic [95:0]  i_non,
  input  logic [31:0]  i_cnt,
  output logic [511:0] o_block,
  output logic         o_done
);

  localparam logic [7:0] RUN_TC = 8'(CORE_LAT - 4);

  core_state_e       state_q, state_d;
  logic [15:0][31:0] x_q, x_d, blk_q, blk_d, init;
  logic [7:0]        tmr_q, tmr_d;
  logic [1:0]        ph_q, ph_d;
  logic [2:0]        qr_q, qr_d;
  logic [3:0]        ia, ib, ic, id;
  logic [31:0]       a, b, c, d, a_n, b_n, c_n, d_n;

  // Inputs feed the final add as well, so they must stay put until done.
  assign init    = {i_non, i_cnt, i_key, CHACHA_C};
  assign o_block = blk_q;

  // qr 0..3 are column rounds, 4..7 diagonal rounds.
  always_comb begin
    ia = {2'b00, qr_q[1:0]};
    ib = {2'b01, qr_q[1:0]};
    ic = {2'b10, qr_q[1:0]};
    id = {2'b11, qr_q[1:0]};
    if (qr_q[2]) begin
      ib = {2'b01, qr_q[1:0] + 2'd1};
      ic = {2'b10, qr_q[1:0] + 2'd2};
      id = {2'b11, qr_q[1:0] + 2'd3};
    end
  end

  always_comb begin
    a   = x_q[ia];
    b   = x_q[ib];
    c   = x_q[ic];
    d   = x_q[id];
    a_n = a;
    b_n = b;
    c_n = c;
    d_n = d;
    unique case (ph_q)
      2'd0: begin
        a_n = a + b;
        d_n = rotl(d ^ a_n, 16);
        c_n = c + d_n;
        b_n = rotl(b ^ c_n, 12);
      end
      2'd1: begin
        a_n = a + b;
        d_n = rotl(d ^ a_n, 8);
      end
      default: begin
        c_n = c + d;
        b_n = rotl(b ^ c_n, 7);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    blk_d   = blk_q;
    tmr_d   = tmr_q;
    ph_d    = ph_q;
    qr_d    = qr_q;
    o_done  = 1'b0;
    unique case (state_q)
      C_IDLE: if (i_qr) state_d = C_LOAD;
      C_LOAD: begin
        x_d     = init;
        tmr_d   = RUN_TC;
        ph_d    = 2'd0;
        qr_d    = 3'd0;
        state_d = C_RUN;
      end
      C_RUN: begin
        x_d[ia] = a_n;
        x_d[ib] = b_n;
        x_d[ic] = c_n;
        x_d[id] = d_n;
        if (ph_q == 2'd2) begin
          ph_d = 2'd0;
          qr_d = qr_q + 3'd1;
        end else begin
          ph_d = ph_q + 2'd1;
        end
        if (tmr_q == 8'd0) state_d = C_ADD;
        else tmr_d = tmr_q - 8'd1;
      end
      C_ADD: begin
        for (int i = 0; i < 16; i++) blk_d[i] = x_q[i] + init[i];
        state_d = C_DONE;
      end
      C_DONE: begin
        o_done  = 1'b1;
        state_d = i_qr ? C_LOAD : C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q <= C_IDLE;
      x_q     <= '0;
      blk_q   <= '0;
      tmr_q   <= '0;
      ph_q    <= '0;
      qr_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      blk_q   <= blk_d;
      tmr_q   <= tmr_d;
      ph_q    <= ph_d;
      qr_q    <= qr_d;
    end
  end

endmodule

// File: rtl/cc_ctrl.sv
// ChaCha20 keystream job controller: sequences cc_block over i_nblk counters with one block of prefetch.
// IDLE wait start | REQ pulse core request | WAIT core running | HOLD block ready, slot full | CAPT take block | FIN wait last accept
module cc_ctrl
  import cc_pkg::*;
(
  input logic  i_clk,
  input logic  i_rst,
  cc_if.slave  bus
);

  state_e       state_q, state_d;
  logic [255:0] key_q, key_d;
  logic [95:0]  non_q, non_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [15:0]  rem_q, rem_d;
  logic [511:0] ks_q, ks_d;
  logic         ks_valid_q, ks_valid_d, ks_last_q, ks_last_d;
  logic         done_q, done_d, err_q, err_d;
  logic         core_qr, core_done, accept, slot_free, ovf;
  logic [511:0] core_block;

  cc_block u_core (
    .i_clk   (i_clk),
    .i_rst_b (~i_rst),
    .i_qr    (core_qr),
    .i_key   (key_q),
    .i_non   (non_q),
    .i_cnt   (cnt_q),
    .o_block (core_block),
    .o_done  (core_done)
  );

  // Last counter of the job (cnt + nblk - 1) would not fit in 32 bits.
  assign ovf       = ({1'b0, bus.i_cnt} + {17'd0, bus.i_nblk}) > 33'h1_0000_0000;
  assign accept    = ks_valid_q & bus.i_ks_ready;
  assign slot_free = ~ks_valid_q | bus.i_ks_ready;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    non_d      = non_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    ks_d       = ks_q;
    ks_valid_d = ks_valid_q;
    ks_last_d  = ks_last_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    core_qr    = 1'b0;
    if (accept) begin
      ks_valid_d = 1'b0;
      ks_last_d  = 1'b0;
    end
    unique case (state_q)
      S_IDLE: if (bus.i_start) begin
        key_d = bus.i_key;
        non_d = bus.i_non;
        cnt_d = bus.i_cnt;
        rem_d = bus.i_nblk;
        if (bus.i_nblk == 16'd0) done_d = 1'b1;
        else if (ovf) err_d = 1'b1;
        else state_d = S_REQ;
      end
      S_REQ: begin
        core_qr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (core_done) state_d = slot_free ? S_CAPT : S_HOLD;
      S_HOLD: if (slot_free) state_d = S_CAPT;
      S_CAPT: begin
        ks_d       = core_block;
        ks_valid_d = 1'b1;
        ks_last_d  = (rem_q == 16'd1);
        cnt_d      = cnt_q + 32'd1;
        rem_d      = rem_q - 16'd1;
        state_d    = (rem_q == 16'd1) ? S_FIN : S_REQ;
      end
      S_FIN: if (accept) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      non_q      <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      ks_q       <= '0;
      ks_valid_q <= 1'b0;
      ks_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      non_q      <= non_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      ks_q       <= ks_d;
      ks_valid_q <= ks_valid_d;
      ks_last_q  <= ks_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_ks       = ks_q;
  assign bus.o_ks_valid = ks_valid_q;
  assign bus.o_ks_last  = ks_last_q;
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_cc_ctrl.sv
// Directed bench for cc_ctrl: RFC 8439 vector, multi-block, backpressure, error, empty job, reset.
module tb_cc_ctrl;

  localparam logic [255:0] KEY = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [95:0]  NON = 96'h00000000_4a000000_09000000;
  localparam logic [511:0] RFC_BLK = 512'h4e3c50a2_e883d0cb_b94e16de_d19c12b5_a2028bd9_05d7c214_09aa9f07_466482d2_4e6cd4c3_9aaa2204_0368c033_c7f4d1c7_c47120a3_1fdd0f50_15593bd1_e4e7f110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   n_req = 0, n_done = 0, n_vcyc = 0, n_err = 0;

  cc_if bus ();

  cc_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.core_qr)    n_req++;
    if (bus.o_done)     n_done++;
    if (bus.o_ks_valid) n_vcyc++;
    if (bus.o_err)      n_err++;
  end

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start is sampled at the end of cycle 0; returns in cycle 1 with scrambled inputs.
  task automatic start_job(input logic [31:0] c, input logic [15:0] nb);
    bus.i_key   = KEY;
    bus.i_non   = NON;
    bus.i_cnt   = c;
    bus.i_nblk  = nb;
    bus.i_start = 1'b1;
    cyc = 0;
    step();
    bus.i_start = 1'b0;
    bus.i_key   = ~KEY;
    bus.i_cnt   = ~c;
    bus.i_nblk  = ~nb;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n = 0;
    while (!bus.o_ks_valid && n < budget) begin
      step();
      n++;
    end
    ok = bus.o_ks_valid;
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [127:0] m_qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = rl(d ^ a, 16); c = c + d; b = rl(b ^ c, 12);
    a = a + b; d = rl(d ^ a, 8);  c = c + d; b = rl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] cc_model(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32 * i +: 32];
    s[12] = c;
    s[13] = n[31:0];
    s[14] = n[63:32];
    s[15] = n[95:64];
    x = s;
    for (int dr = 0; dr < 10; dr++) begin
      {x[0], x[4], x[8],  x[12]} = m_qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = m_qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = m_qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = m_qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = m_qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = m_qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = m_qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = m_qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = x[i] + s[i];
    return r;
  endfunction

  initial begin
    bit ok, stable;
    int r0, d0, v0, e0;
    logic [511:0] first;

    bus.i_key = '0; bus.i_non = '0; bus.i_cnt = '0; bus.i_nblk = '0;
    bus.i_start = 1'b0; bus.i_ks_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (3) step();
    check("rst_ks", bus.o_ks, '0);
    check("rst_valid", bus.o_ks_valid, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_err", bus.o_err, 0);
    rst = 1'b0;
    step();

    // RFC 8439 2.3.2 vector, single block
    bus.i_ks_ready = 1'b1;
    start_job(32'd1, 16'd1);
    check("a_busy", bus.o_busy, 1);
    wait_valid(300, ok);
    check("a_timeout", ok, 1);
    check("a_lat", cyc, 246);
    check("a_ks", bus.o_ks, RFC_BLK);
    check("a_last", bus.o_ks_last, 1);
    step();
    check("a_done", bus.o_done, 1);
    check("a_valid_off", bus.o_ks_valid, 0);
    step();
    check("a_done_pulse", bus.o_done, 0);
    check("a_idle", bus.o_busy, 0);

    // three blocks, ready high
    d0 = n_done;
    start_job(32'd7, 16'd3);
    for (int b = 0; b < 3; b++) begin
      wait_valid(300, ok);
      check("b_timeout", ok, 1);
      check("b_lat", cyc, 246 + 245 * b);
      check("b_ks", bus.o_ks, cc_model(KEY, NON, 32'd7 + 32'(b)));
      check("b_last", bus.o_ks_last, (b == 2));
      step();
    end
    check("b_done", bus.o_done, 1);
    repeat (5) step();
    check("b_ndone", n_done - d0, 1);

    // backpressure: ready low until cycle 600, stray start at 300 must be ignored
    bus.i_ks_ready = 1'b0;
    r0 = n_req;
    start_job(32'd20, 16'd2);
    wait_valid(300, ok);
    check("c_timeout", ok, 1);
    check("c_lat", cyc, 246);
    first = bus.o_ks;
    check("c_ks0", first, cc_model(KEY, NON, 32'd20));
    check("c_last0", bus.o_ks_last, 0);
    stable = 1'b1;
    while (cyc < 600) begin
      bus.i_start = (cyc == 300);
      step();
      if (!bus.o_ks_valid || bus.o_ks !== first) stable = 1'b0;
    end
    bus.i_start = 1'b0;
    check("c_stable", stable, 1);
    check("c_nreq", n_req - r0, 2);
    bus.i_ks_ready = 1'b1;
    step();
    bus.i_ks_ready = 1'b0;
    check("c_gap", bus.o_ks_valid, 0);
    step();
    check("c_valid2", bus.o_ks_valid, 1);
    check("c_ks1", bus.o_ks, cc_model(KEY, NON, 32'd21));
    check("c_last1", bus.o_ks_last, 1);
    bus.i_ks_ready = 1'b1;
    step();
    check("c_done", bus.o_done, 1);
    step();

    // counter overflow
    r0 = n_req;
    d0 = n_done;
    start_job(32'hFFFF_FFFF, 16'd2);
    check("d_err", bus.o_err, 1);
    check("d_busy", bus.o_busy, 0);
    step();
    check("d_err_pulse", bus.o_err, 0);
    check("d_busy2", bus.o_busy, 0);
    repeat (3) step();
    check("d_nreq", n_req - r0, 0);
    check("d_ndone", n_done - d0, 0);

    // empty job
    r0 = n_req;
    v0 = n_vcyc;
    start_job(32'd5, 16'd0);
    check("e_done", bus.o_done, 1);
    check("e_busy", bus.o_busy, 0);
    step();
    check("e_done_pulse", bus.o_done, 0);
    repeat (5) step();
    check("e_nvalid", n_vcyc - v0, 0);
    check("e_nreq", n_req - r0, 0);

    // last counter exactly 0xFFFFFFFF is legal
    e0 = n_err;
    start_job(32'hFFFF_FFFF, 16'd1);
    wait_valid(300, ok);
    check("g_timeout", ok, 1);
    check("g_ks", bus.o_ks, cc_model(KEY, NON, 32'hFFFF_FFFF));
    check("g_last", bus.o_ks_last, 1);
    step();
    check("g_done", bus.o_done, 1);
    check("g_nerr", n_err - e0, 0);

    // reset mid-job, then a clean job
    start_job(32'd3, 16'd1);
    while (cyc < 100) step();
    rst = 1'b1;
    step();
    check("f_ks", bus.o_ks, '0);
    check("f_valid", bus.o_ks_valid, 0);
    check("f_last", bus.o_ks_last, 0);
    check("f_busy", bus.o_busy, 0);
    rst = 1'b0;
    d0 = n_done;
    v0 = n_vcyc;
    repeat (300) step();
    check("f_ndone", n_done - d0, 0);
    check("f_nvalid", n_vcyc - v0, 0);
    start_job(32'd1, 16'd1);
    wait_valid(300, ok);
    check("f_timeout", ok, 1);
    check("f_lat", cyc, 246);
    check("f_ks2", bus.o_ks, RFC_BLK);
    step();
    check("f_done", bus.o_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
